// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// The request bundle is sized by AW_DEF/DW_DEF; the arbiter's AW/DW must match them.
package dmem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } mem_req_t;

    // Saturating 16-bit increment for the activity counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way picker: a lone requester wins; on a tie, port 0 wins when fixed priority
// is selected or when port 1 held the last grant, otherwise port 1 wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] grant
);

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (fixed || last) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory, with lock ownership and 1-cycle reads.
// Optional macro DMEM_ARB_STATS_EN adds saturating grant/stall counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int PRIO_FIXED = 0
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1,
    output logic [15:0]   stat_stall
`endif
);

    arb_state_t r_state;
    logic       r_last_gnt;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic [1:0] w_pick;
    logic [1:0] w_gnt;
    logic       w_fixed;
    mem_req_t   w_sel;

    assign w_fixed = (PRIO_FIXED != 0) ? 1'b1 : 1'b0;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (r_last_gnt),
        .fixed (w_fixed),
        .grant (w_pick)
    );

    // Grant qualification: a lock owner shuts the other port out; nothing is granted in reset
    always_comb begin
        w_gnt = 2'b00;
        if (!reset_n) begin
            w_gnt = 2'b00;
        end else begin
            case (r_state)
                IDLE:    w_gnt = w_pick;
                OWN0:    w_gnt = {1'b0, req0};
                OWN1:    w_gnt = {req1, 1'b0};
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // Route the granted port onto the memory bus
    always_comb begin
        w_sel = '{we: 1'b0, addr: {AW_DEF{1'b0}}, wdata: {DW_DEF{1'b0}}};
        case (w_gnt)
            2'b01:   w_sel = '{we: we0, addr: addr0, wdata: wdata0};
            2'b10:   w_sel = '{we: we1, addr: addr1, wdata: wdata1};
            default: w_sel = '{we: 1'b0, addr: {AW_DEF{1'b0}}, wdata: {DW_DEF{1'b0}}};
        endcase
    end

    assign gnt0      = w_gnt[0];
    assign gnt1      = w_gnt[1];
    assign mem_en    = |w_gnt;
    assign mem_we    = w_sel.we;
    assign mem_addr  = w_sel.addr;
    assign mem_wdata = w_sel.wdata;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rvalid0 ? mem_rdata : {DW{1'b0}};
    assign rdata1    = r_rvalid1 ? mem_rdata : {DW{1'b0}};

    // Ownership FSM, tie-break history and read-return flags
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt[0] & ~we0;
            r_rvalid1 <= w_gnt[1] & ~we1;
            if (|w_gnt) begin
                r_last_gnt <= w_gnt[1];
            end
            case (r_state)
                IDLE: begin
                    if (w_gnt[0] && lock0) begin
                        r_state <= OWN0;
                    end else if (w_gnt[1] && lock1) begin
                        r_state <= OWN1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                // While owning, a request is always granted, so dropping req or lock releases
                OWN0: begin
                    if (!req0 || !lock0) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= OWN0;
                    end
                end
                OWN1: begin
                    if (!req1 || !lock1) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= OWN1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_stat_gnt0;
    logic [15:0] r_stat_gnt1;
    logic [15:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = (req0 & ~w_gnt[0]) | (req1 & ~w_gnt[1]);

    // Saturating activity counters
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_gnt0  <= 16'd0;
            r_stat_gnt1  <= 16'd0;
            r_stat_stall <= 16'd0;
        end else begin
            r_stat_gnt0  <= sat_inc16(r_stat_gnt0, w_gnt[0]);
            r_stat_gnt1  <= sat_inc16(r_stat_gnt1, w_gnt[1]);
            r_stat_stall <= sat_inc16(r_stat_stall, w_stall);
        end
    end

    assign stat_gnt0  = r_stat_gnt0;
    assign stat_gnt1  = r_stat_gnt1;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share one stimulus plan,
// each with its own memory, checked by a scoreboard against a request-level reference model.
module tb_dmem_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_n;
    logic       req_a   [2][2];
    logic       we_a    [2][2];
    logic       lock_a  [2][2];
    logic [7:0] addr_a  [2][2];
    logic [7:0] wdata_a [2][2];
    logic       gnt_a   [2][2];
    logic       rvalid_a[2][2];
    logic [7:0] rdata_a [2][2];
    logic       mem_en_a   [2];
    logic       mem_we_a   [2];
    logic [7:0] mem_addr_a [2];
    logic [7:0] mem_wdata_a[2];
    logic [7:0] rd_q       [2];
    logic [7:0] mem_arr    [2][256];
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] sg0_a[2];
    logic [15:0] sg1_a[2];
    logic [15:0] sst_a[2];
`endif

    dmem_arbiter #(.AW(8), .DW(8), .PRIO_FIXED(0)) u_rr (
        .CLK(CLK), .reset_n(rst_n),
        .req0(req_a[0][0]), .we0(we_a[0][0]), .lock0(lock_a[0][0]), .addr0(addr_a[0][0]), .wdata0(wdata_a[0][0]),
        .gnt0(gnt_a[0][0]), .rvalid0(rvalid_a[0][0]), .rdata0(rdata_a[0][0]),
        .req1(req_a[0][1]), .we1(we_a[0][1]), .lock1(lock_a[0][1]), .addr1(addr_a[0][1]), .wdata1(wdata_a[0][1]),
        .gnt1(gnt_a[0][1]), .rvalid1(rvalid_a[0][1]), .rdata1(rdata_a[0][1]),
        .mem_en(mem_en_a[0]), .mem_we(mem_we_a[0]), .mem_addr(mem_addr_a[0]), .mem_wdata(mem_wdata_a[0]),
        .mem_rdata(rd_q[0])
`ifdef DMEM_ARB_STATS_EN
        , .stat_gnt0(sg0_a[0]), .stat_gnt1(sg1_a[0]), .stat_stall(sst_a[0])
`endif
    );

    dmem_arbiter #(.AW(8), .DW(8), .PRIO_FIXED(1)) u_fx (
        .CLK(CLK), .reset_n(rst_n),
        .req0(req_a[1][0]), .we0(we_a[1][0]), .lock0(lock_a[1][0]), .addr0(addr_a[1][0]), .wdata0(wdata_a[1][0]),
        .gnt0(gnt_a[1][0]), .rvalid0(rvalid_a[1][0]), .rdata0(rdata_a[1][0]),
        .req1(req_a[1][1]), .we1(we_a[1][1]), .lock1(lock_a[1][1]), .addr1(addr_a[1][1]), .wdata1(wdata_a[1][1]),
        .gnt1(gnt_a[1][1]), .rvalid1(rvalid_a[1][1]), .rdata1(rdata_a[1][1]),
        .mem_en(mem_en_a[1]), .mem_we(mem_we_a[1]), .mem_addr(mem_addr_a[1]), .mem_wdata(mem_wdata_a[1]),
        .mem_rdata(rd_q[1])
`ifdef DMEM_ARB_STATS_EN
        , .stat_gnt0(sg0_a[1]), .stat_gnt1(sg1_a[1]), .stat_stall(sst_a[1])
`endif
    );

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        if (a == 0) v = 8'hFF;
        else if (a == 1) v = 8'h07;
        else v = 8'(a * 37 + 11);
        return v;
    endfunction

    // Behavioural single-port memory per instance, reloaded while reset is low
    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int a = 0; a < 256; a++) mem_arr[d][a] <= init_val(a);
            end else if (mem_en_a[d]) begin
                if (mem_we_a[d]) mem_arr[d][mem_addr_a[d]] <= mem_wdata_a[d];
                else rd_q[d] <= mem_arr[d][mem_addr_a[d]];
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Reference model: owner is -1 (free), 0 or 1; last is the port that won most recently
    int          owner[2];
    int          last_m[2];
    logic [7:0]  ref_mem[2][256];
    logic [7:0]  sbq[4][$];
    int          e_g0[2], e_g1[2], e_st[2];
    int          rst_events = 0;
    int          seen_rst = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1;
            last_m[d] = 1;
            e_g0[d] = 0; e_g1[d] = 0; e_st[d] = 0;
            for (int a = 0; a < 256; a++) ref_mem[d][a] = init_val(a);
            for (int p = 0; p < 2; p++) sbq[d*2+p].delete();
        end
    endtask

    task automatic model_step(input int d);
        bit g[2];
        bit r0, r1;
        for (int p = 0; p < 2; p++) begin
            bit ev;
            logic [7:0] e;
            ev = (sbq[d*2+p].size() != 0);
            chk(p == 0 ? "rvalid0" : "rvalid1", d, 64'(rvalid_a[d][p]), 64'(ev));
            if (ev) begin
                e = sbq[d*2+p].pop_front();
                chk(p == 0 ? "rdata0" : "rdata1", d, 64'(rdata_a[d][p]), 64'(e));
            end else begin
                chk(p == 0 ? "rdata0_idle" : "rdata1_idle", d, 64'(rdata_a[d][p]), 64'd0);
            end
        end
        r0 = req_a[d][0];
        r1 = req_a[d][1];
        if (owner[d] == 0) begin
            g[0] = r0; g[1] = 1'b0;
        end else if (owner[d] == 1) begin
            g[0] = 1'b0; g[1] = r1;
        end else if (r0 && r1) begin
            g[0] = (d == 1) || (last_m[d] == 1);
            g[1] = !g[0];
        end else begin
            g[0] = r0; g[1] = r1;
        end
        chk("gnt0", d, 64'(gnt_a[d][0]), 64'(g[0]));
        chk("gnt1", d, 64'(gnt_a[d][1]), 64'(g[1]));
        if ((r0 && !g[0]) || (r1 && !g[1])) e_st[d] = (e_st[d] < 65535) ? e_st[d] + 1 : 65535;
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                if (we_a[d][p]) ref_mem[d][addr_a[d][p]] = wdata_a[d][p];
                else sbq[d*2+p].push_back(ref_mem[d][addr_a[d][p]]);
                if (p == 0) e_g0[d] = (e_g0[d] < 65535) ? e_g0[d] + 1 : 65535;
                else e_g1[d] = (e_g1[d] < 65535) ? e_g1[d] + 1 : 65535;
                last_m[d] = p;
            end
        end
        if (owner[d] == -1) begin
            if (g[0] && lock_a[d][0]) owner[d] = 0;
            else if (g[1] && lock_a[d][1]) owner[d] = 1;
        end else if (!req_a[d][owner[d]] || !lock_a[d][owner[d]]) begin
            owner[d] = -1;
        end
    endtask

    // Monitor: compares every DUT output at the falling edge against the model
    always @(negedge CLK) begin
        if (rst_events != seen_rst) begin
            seen_rst = rst_events;
            model_reset();
        end
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk("reset_outputs", d,
                    64'({gnt_a[d][0], gnt_a[d][1], rvalid_a[d][0], rvalid_a[d][1], rdata_a[d][0], rdata_a[d][1],
                         mem_en_a[d], mem_we_a[d], mem_addr_a[d], mem_wdata_a[d]}), 64'd0);
            end
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    int phase;
    int step[2];
    bit granted[2][2];

    task automatic gen(input int d, input int p);
        req_a[d][p] = 1'b0; we_a[d][p] = 1'b0; lock_a[d][p] = 1'b0;
        addr_a[d][p] = 8'd0; wdata_a[d][p] = 8'd0;
        case (phase)
            0, 1, 5: begin
                req_a[d][p] = 1'b1; addr_a[d][p] = 8'(p);
            end
            2: begin
                if (p == 0) begin
                    req_a[d][p] = 1'b1; addr_a[d][p] = 8'd4;
                end else if (step[d] == 0) begin
                    req_a[d][p] = 1'b1; we_a[d][p] = 1'b1; lock_a[d][p] = 1'b1;
                    addr_a[d][p] = 8'd2; wdata_a[d][p] = 8'h01;
                end else if (step[d] == 1) begin
                    req_a[d][p] = 1'b1; we_a[d][p] = 1'b1;
                    addr_a[d][p] = 8'd3; wdata_a[d][p] = 8'h00;
                end
            end
            3: begin
                req_a[d][p]   = ($urandom_range(0, 3) != 0);
                we_a[d][p]    = 1'($urandom_range(0, 1));
                lock_a[d][p]  = ($urandom_range(0, 3) == 0);
                addr_a[d][p]  = 8'($urandom_range(0, 15));
                wdata_a[d][p] = 8'($urandom);
            end
            6: if (p == 0) begin req_a[d][p] = 1'b1; addr_a[d][p] = 8'd5; end
            7: if (p == 1) begin req_a[d][p] = 1'b1; addr_a[d][p] = 8'd6; end
            default: req_a[d][p] = 1'b0;
        endcase
    endtask

    // Requester behaviour: hold the request until granted, then present the next one
    task automatic drive_cycle();
        @(negedge CLK);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) granted[d][p] = gnt_a[d][p];
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (phase == 2 && granted[d][1]) step[d]++;
            for (int p = 0; p < 2; p++)
                if (!(req_a[d][p] && !granted[d][p])) gen(d, p);
        end
    endtask

    task automatic run(input int ph, input int n);
        phase = ph;
        repeat (n) drive_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        phase = 0;
        step[0] = 0; step[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) gen(d, p);
        run(0, 3);
        rst_n = 1'b1;
        run(1, 8);
        run(4, 6);
        step[0] = 0; step[1] = 0;
        run(2, 6);
        run(4, 3);
        chk("lock_pair_mem", 0, 64'({mem_arr[0][3], mem_arr[0][2]}), 64'h0001);
        run(3, 400);
        run(4, 6);
        run(6, 1);
        @(negedge CLK);
        #1;
        rst_n = 1'b0;
        rst_events++;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) req_a[d][p] = 1'b0;
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        phase = 7;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) gen(d, p);
        run(7, 2);
        run(3, 150);
        run(4, 6);
        run(5, 10);
        run(4, 4);
`ifdef DMEM_ARB_STATS_EN
        for (int d = 0; d < 2; d++) begin
            chk("stat_gnt0", d, 64'(sg0_a[d]), 64'(e_g0[d]));
            chk("stat_gnt1", d, 64'(sg1_a[d]), 64'(e_g1[d]));
            chk("stat_stall", d, 64'(sst_a[d]), 64'(e_st[d]));
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 256x8 data memory between two requesters: port 0 (processor core load/store unit) and port 1 (preload/readout engine used to initialise constants and dump results around start/halt).
- Sits between both requesters and the data memory instance.
- Round-robin or fixed-priority arbitration, with a lock for multi-byte atomic sequences such as 16-bit operands stored as byte pairs.
- Fixed 1-cycle read latency.

Parameters:
AW, 8, address width (256 bytes)
DW, 8, data width
PRIO_FIXED, 0, 0 = round robin; 1 = port 0 always wins contention

Ports:
CLK  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0  input  1  port 0 access request
we0  input  1  port 0 write enable (1 = write, 0 = read)
lock0  input  1  port 0 holds ownership after the current grant
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
gnt0  output  1  port 0 access issued this cycle
rvalid0  output  1  port 0 read data valid
rdata0  output  DW  port 0 read data
req1, we1, lock1, addr1, wdata1  input  1/1/1/AW/DW  port 1 equivalents
gnt1, rvalid1, rdata1  output  1/1/DW  port 1 equivalents
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we = 0

Behaviour:
- One clock domain. Reset is asynchronous and active-low: reset_n low clears all state immediately.
- While reset_n is low: state = IDLE, last_gnt = 1 (port 0 wins first tie), all outputs 0.
- Grant timing:
  - gnt0/gnt1 are combinational from the req inputs and the registered state; at most one is high per cycle.
  - The granted port's we/addr/wdata drive mem_* in the same cycle, with mem_en = 1.
  - With no grant, mem_en = mem_we = 0 and mem_addr/mem_wdata = 0.
- Read return:
  - A granted read raises rvalidN exactly one cycle later, with rdataN = mem_rdata.
  - The non-owning port's rdata reads 0.
  - A pending rvalid is registered: it still fires after the owner's next-cycle change.
- Writes complete in the grant cycle; no rvalid is produced for a write.
- FSM states:
  - IDLE → OWN0 when port 0 is granted with lock0 = 1.
  - IDLE → OWN1 when port 1 is granted with lock1 = 1.
  - OWNn: only port n can be granted; the other port stalls (gnt = 0) even if it is requesting.
  - OWNn → IDLE when, in a cycle, port n has a grant with lockN = 0, or reqN = 0 while in OWNn (release without access).
- Arbitration in IDLE:
  - One requester: it wins.
  - Both requesting with PRIO_FIXED = 0: the port not in last_gnt wins.
  - Both requesting with PRIO_FIXED = 1: port 0 always wins.
  - last_gnt updates on every grant.
- Back-to-back: one access per cycle sustained; there are no bubbles between grants.
- Requesters hold req/addr/we/wdata stable until they see gnt. The arbiter stores no request.
- Reset mid-operation: lock ownership and any pending rvalid are dropped; no rvalid appears after reset is released.

Optional Feature:
Macro: DMEM_ARB_STATS_EN
- Defined: adds outputs stat_gnt0 [15:0], stat_gnt1 [15:0] and stat_stall [15:0].
  - stat_stall counts cycles in which some req is high without its gnt.
  - All three counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters do not exist; functional behaviour is identical.

Decomposition:
Shared package dmem_arb_pkg holds:
- typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
- localparams AW_DEF = 8, DW_DEF = 8
- typedef struct mem_req_t {we, addr, wdata}

Sub-module rr_pick2 (2-way round-robin/fixed-priority picker): inputs req[1:0], last, fixed; output one-hot grant. It is combinational, instantiated once.

Test Plan:
- Reset: reset_n = 0 with req0 = req1 = 1 → all outputs 0. Release, both reading addr 0/1 → gnt0 first cycle, then gnt1; rvalid0 carries mem[0] = 8'hFF, rvalid1 carries mem[1] = 8'h07.
- Round robin: both reading continuously for 6 cycles → gnt pattern 0,1,0,1,0,1. Each rvalid appears one cycle after its gnt.
- Lock: port 1 writes addr 2 = 8'h01 with lock1 = 1, then addr 3 = 8'h00 with lock1 = 0, while port 0 requests throughout → gnt0 = 0 for both cycles, granted on the third. mem[3:2] = 16'h0001.
- Fixed priority: PRIO_FIXED = 1, both requesting 4 cycles → gnt0 all 4 cycles, gnt1 never. After req0 drops → gnt1 the next cycle.
- Mid-operation reset: port 0 issues a read, reset_n is pulsed low the next cycle → rvalid0 stays 0. After release, state = IDLE and a port 1 request is granted immediately.
- DMEM_ARB_STATS_EN defined: 10 contended cycles → stat_stall = 10, stat_gnt0 + stat_gnt1 = 10.
